// File: rtl/hsc_cpi_sequencer.sv
// rtl/hsc_cpi_sequencer.sv - dwell-table driven PRI/CPI timing sequencer
module hsc_cpi_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_Tbl_We,
    input  logic [2:0]  i_Tbl_Addr,
    input  logic [34:0] i_Tbl_Wdata,
    input  logic [2:0]  i_Last_Idx,
    input  logic        i_Loop,
    input  logic        i_Start,
    input  logic        i_Stop,
    output logic        o_Busy,
    output logic        o_PRI_p,
    output logic        o_CPI_p,
    output logic        o_First_PRI,
    output logic        o_SRIO_Mem_Sel,
    output logic [2:0]  o_Waveform_Type,
    output logic [15:0] o_PRI_Width,
    output logic [2:0]  o_Dwell_Idx,
    output logic        o_Done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t      state;
    logic [34:0] dwell_tbl [8];

    // Counters for the dwell in progress; 16 bits always suffice because the
    // limits are checked before the increment.
    logic [15:0] pri_cnt;
    logic [15:0] pri_idx;
    logic [15:0] cur_cpi;

    // Entry prefetched at the start of each CPI so the next dwell begins with no gap.
    logic [2:0]  nxt_wave;
    logic [15:0] nxt_pri;
    logic [15:0] nxt_cpi;
    logic [2:0]  nxt_idx;

    logic [2:0]  last_idx_q;
    logic        loop_q;
    logic        stop_pend;

    logic [34:0] load_entry;
    logic [34:0] pf_entry;
    logic [2:0]  pf_idx;
    logic        pri_last;
    logic        cpi_last;

    // A PRI shorter than 2 cycles would overlap the prefetch with the CPI end.
    function automatic logic [15:0] eff_pri(input logic [15:0] w);
        eff_pri = (w < 16'd2) ? 16'd2 : w;
    endfunction

    function automatic logic [15:0] eff_cpi(input logic [15:0] w);
        eff_cpi = (w < 16'd1) ? 16'd1 : w;
    endfunction

    assign load_entry = dwell_tbl[o_Dwell_Idx];
    assign pf_idx     = (o_Dwell_Idx == last_idx_q) ? 3'd0 : o_Dwell_Idx + 3'd1;
    assign pf_entry   = dwell_tbl[pf_idx];
    assign pri_last   = (pri_cnt == o_PRI_Width - 16'd1);
    assign cpi_last   = (pri_idx == cur_cpi - 16'd1);

    // Dwell table: written in any state, deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (i_Tbl_We) begin
            dwell_tbl[i_Tbl_Addr] <= i_Tbl_Wdata;
        end
    end

    // Sequencer FSM with registered outputs and PRI/CPI counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            pri_cnt         <= 16'd0;
            pri_idx         <= 16'd0;
            cur_cpi         <= 16'd0;
            nxt_wave        <= 3'd0;
            nxt_pri         <= 16'd0;
            nxt_cpi         <= 16'd0;
            nxt_idx         <= 3'd0;
            last_idx_q      <= 3'd0;
            loop_q          <= 1'b0;
            stop_pend       <= 1'b0;
            o_Busy          <= 1'b0;
            o_PRI_p         <= 1'b0;
            o_CPI_p         <= 1'b0;
            o_First_PRI     <= 1'b0;
            o_SRIO_Mem_Sel  <= 1'b0;
            o_Waveform_Type <= 3'd0;
            o_PRI_Width     <= 16'd0;
            o_Dwell_Idx     <= 3'd0;
            o_Done          <= 1'b0;
        end else begin
            o_PRI_p <= 1'b0;
            o_CPI_p <= 1'b0;
            o_Done  <= 1'b0;

            if ((state == S_LOAD || state == S_RUN) && i_Stop) begin
                stop_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (i_Start && !i_Stop) begin
                        last_idx_q  <= i_Last_Idx;
                        loop_q      <= i_Loop;
                        o_Dwell_Idx <= 3'd0;
                        o_Busy      <= 1'b1;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    o_Waveform_Type <= load_entry[34:32];
                    o_PRI_Width     <= eff_pri(load_entry[31:16]);
                    cur_cpi         <= eff_cpi(load_entry[15:0]);
                    pri_cnt         <= 16'd0;
                    pri_idx         <= 16'd0;
                    o_PRI_p         <= 1'b1;
                    o_CPI_p         <= 1'b1;
                    o_First_PRI     <= 1'b1;
                    state           <= S_RUN;
                end
                S_RUN: begin
                    if (o_CPI_p) begin
                        nxt_wave <= pf_entry[34:32];
                        nxt_pri  <= eff_pri(pf_entry[31:16]);
                        nxt_cpi  <= eff_cpi(pf_entry[15:0]);
                        nxt_idx  <= pf_idx;
                    end
                    if (!pri_last) begin
                        pri_cnt <= pri_cnt + 16'd1;
                    end else begin
                        pri_cnt <= 16'd0;
                        if (!cpi_last) begin
                            pri_idx     <= pri_idx + 16'd1;
                            o_PRI_p     <= 1'b1;
                            o_First_PRI <= 1'b0;
                        end else begin
                            o_SRIO_Mem_Sel <= ~o_SRIO_Mem_Sel;
                            pri_idx        <= 16'd0;
                            if (stop_pend || (o_Dwell_Idx == last_idx_q && !loop_q)) begin
                                o_Busy      <= 1'b0;
                                o_First_PRI <= 1'b0;
                                o_Done      <= 1'b1;
                                state       <= S_DONE;
                            end else begin
                                o_Waveform_Type <= nxt_wave;
                                o_PRI_Width     <= nxt_pri;
                                cur_cpi         <= nxt_cpi;
                                o_Dwell_Idx     <= nxt_idx;
                                o_PRI_p         <= 1'b1;
                                o_CPI_p         <= 1'b1;
                                o_First_PRI     <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    stop_pend <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hsc_cpi_sequencer.sv
// tb/tb_hsc_cpi_sequencer.sv - scoreboard bench for hsc_cpi_sequencer
module tb_hsc_cpi_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_Tbl_We = 1'b0;
    logic [2:0]  i_Tbl_Addr = 3'd0;
    logic [34:0] i_Tbl_Wdata = 35'd0;
    logic [2:0]  i_Last_Idx = 3'd0;
    logic        i_Loop = 1'b0;
    logic        i_Start = 1'b0;
    logic        i_Stop = 1'b0;
    logic        o_Busy, o_PRI_p, o_CPI_p, o_First_PRI, o_SRIO_Mem_Sel, o_Done;
    logic [2:0]  o_Waveform_Type, o_Dwell_Idx;
    logic [15:0] o_PRI_Width;

    hsc_cpi_sequencer dut (
        .clk(clk), .rst(rst),
        .i_Tbl_We(i_Tbl_We), .i_Tbl_Addr(i_Tbl_Addr), .i_Tbl_Wdata(i_Tbl_Wdata),
        .i_Last_Idx(i_Last_Idx), .i_Loop(i_Loop), .i_Start(i_Start), .i_Stop(i_Stop),
        .o_Busy(o_Busy), .o_PRI_p(o_PRI_p), .o_CPI_p(o_CPI_p), .o_First_PRI(o_First_PRI),
        .o_SRIO_Mem_Sel(o_SRIO_Mem_Sel), .o_Waveform_Type(o_Waveform_Type),
        .o_PRI_Width(o_PRI_Width), .o_Dwell_Idx(o_Dwell_Idx), .o_Done(o_Done)
    );

    always #5 clk = ~clk;

    // Cycle n is the interval after the n-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int cyc;
        bit cpi;
        bit first;
        int wave;
        int pri;
        int idx;
        bit msel;
    } ev_t;

    ev_t         pri_q[$];
    ev_t         done_q[$];
    ev_t         last_ev;
    logic [34:0] mtab [8];
    bit          m_msel = 1'b0;
    bit          mon_on = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [34:0] ent(input int w, input int p, input int c);
        return {w[2:0], p[15:0], c[15:0]};
    endfunction

    // Reference model: one CPI of table entry idx starting at cycle t.
    task automatic plan_cpi(inout int t, input int idx);
        logic [34:0] e;
        int pw, cw;
        ev_t ev;
        e  = mtab[idx];
        pw = (int'(e[31:16]) < 2) ? 2 : int'(e[31:16]);
        cw = (int'(e[15:0]) < 1) ? 1 : int'(e[15:0]);
        for (int p = 0; p < cw; p++) begin
            ev.cyc = t + p * pw;  ev.cpi = (p == 0);  ev.first = (p == 0);
            ev.wave = int'(e[34:32]);  ev.pri = pw;  ev.idx = idx;  ev.msel = m_msel;
            pri_q.push_back(ev);
        end
        last_ev = ev;
        t = t + pw * cw;
        m_msel = ~m_msel;
    endtask

    task automatic plan_done(input int t);
        ev_t ev;
        ev = last_ev;
        ev.cyc = t;
        ev.msel = m_msel;
        done_q.push_back(ev);
    endtask

    // Monitor: pops the scoreboard whenever the DUT emits a pulse.
    bit exp_first = 1'b0;
    bit rst_prev  = 1'b0;
    always @(negedge clk) begin : monitor
        ev_t ev;
        if (mon_on) begin
            if (rst_prev) exp_first = 1'b0;
            if (o_Done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", int'(o_Done), 0);
                end else begin
                    ev = done_q.pop_front();
                    chk("done_cycle", cyc, ev.cyc);
                    chk("done_memsel", int'(o_SRIO_Mem_Sel), int'(ev.msel));
                    chk("done_busy", int'(o_Busy), 0);
                end
                exp_first = 1'b0;
            end
            if (o_PRI_p) begin
                if (pri_q.size() == 0) begin
                    chk("unexpected_pri", int'(o_PRI_p), 0);
                end else begin
                    ev = pri_q.pop_front();
                    chk("pri_cycle", cyc, ev.cyc);
                    chk("cpi_pulse", int'(o_CPI_p), int'(ev.cpi));
                    chk("wave", int'(o_Waveform_Type), ev.wave);
                    chk("pri_width", int'(o_PRI_Width), ev.pri);
                    chk("dwell_idx", int'(o_Dwell_Idx), ev.idx);
                    chk("memsel", int'(o_SRIO_Mem_Sel), int'(ev.msel));
                    chk("run_busy", int'(o_Busy), 1);
                    exp_first = ev.first;
                end
            end else if (o_CPI_p) begin
                chk("cpi_without_pri", int'(o_CPI_p), 0);
            end
            chk("first_pri_level", int'(o_First_PRI), int'(exp_first));
        end
        rst_prev = rst;
    end

    task automatic wr(input int a, input logic [34:0] d);
        i_Tbl_We = 1'b1;  i_Tbl_Addr = a[2:0];  i_Tbl_Wdata = d;
        @(posedge clk); #1;
        i_Tbl_We = 1'b0;
        mtab[a] = d;
    endtask

    // Pulse start; afterwards scramble Last_Idx/Loop, which must be ignored.
    task automatic do_start(input int last, input bit loop);
        i_Start = 1'b1;  i_Last_Idx = last[2:0];  i_Loop = loop;
        @(posedge clk); #1;
        i_Start = 1'b0;  i_Last_Idx = 3'($urandom);  i_Loop = 1'($urandom);
        chk("load_busy", int'(o_Busy), 1);
        chk("load_idx", int'(o_Dwell_Idx), 0);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_stop();
        i_Stop = 1'b1;
        @(posedge clk); #1;
        i_Stop = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((pri_q.size() != 0 || done_q.size() != 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drain"}, pri_q.size() + done_q.size(), 0);
        @(posedge clk); #1;
        chk({name, "_idle_busy"}, int'(o_Busy), 0);
        chk({name, "_hold_wave"}, int'(o_Waveform_Type), last_ev.wave);
        chk({name, "_hold_pri"}, int'(o_PRI_Width), last_ev.pri);
        chk({name, "_hold_idx"}, int'(o_Dwell_Idx), last_ev.idx);
        pri_q.delete();
        done_q.delete();
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_busy"}, int'(o_Busy), 0);
        chk({name, "_pri_p"}, int'(o_PRI_p), 0);
        chk({name, "_cpi_p"}, int'(o_CPI_p), 0);
        chk({name, "_first"}, int'(o_First_PRI), 0);
        chk({name, "_memsel"}, int'(o_SRIO_Mem_Sel), 0);
        chk({name, "_wave"}, int'(o_Waveform_Type), 0);
        chk({name, "_priw"}, int'(o_PRI_Width), 0);
        chk({name, "_idx"}, int'(o_Dwell_Idx), 0);
        chk({name, "_done"}, int'(o_Done), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int t, tp, cs, s;
        ev_t dummy;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;
        mon_on = 1'b1;

        // Single long CPI, with an ignored start mid-run.
        wr(0, ent(3, 130, 5));
        t = cyc;  tp = t + 2;
        plan_cpi(tp, 0);  plan_done(tp);
        do_start(0, 1'b0);
        wait_until(t + 50);
        i_Start = 1'b1;
        @(posedge clk); #1;
        i_Start = 1'b0;
        wait_idle("single");

        // Two dwells back to back.
        wr(0, ent(0, 10, 2));
        wr(1, ent(5, 20, 1));
        t = cyc;  tp = t + 2;
        plan_cpi(tp, 0);  plan_cpi(tp, 1);  plan_done(tp);
        do_start(1, 1'b0);
        wait_idle("multi");

        // Zero widths clamp to PRI 2, CPI 1.
        wr(0, ent(1, 0, 0));
        t = cyc;  tp = t + 2;
        plan_cpi(tp, 0);  plan_done(tp);
        do_start(0, 1'b0);
        wait_idle("clamp");

        // Looping single entry stopped during the second CPI.
        wr(0, ent(2, 10, 3));
        t = cyc;  tp = t + 2;
        plan_cpi(tp, 0);  plan_cpi(tp, 0);  plan_done(tp);
        do_start(0, 1'b1);
        wait_until(t + 45);
        pulse_stop();
        wait_idle("loopstop");

        // Reset during PRI index 2, then a normal restart.
        wr(0, ent(4, 10, 5));
        t = cyc;  tp = t + 2;
        plan_cpi(tp, 0);
        dummy = pri_q.pop_back();
        dummy = pri_q.pop_back();
        do_start(0, 1'b0);
        wait_until(t + 25);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset("midrst");
        rst = 1'b0;
        m_msel = 1'b0;
        chk("midrst_drain", pri_q.size() + done_q.size(), 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        t = cyc;  tp = t + 2;
        plan_cpi(tp, 0);  plan_done(tp);
        do_start(0, 1'b0);
        wait_idle("restart");

        // Start together with stop stays idle.
        i_Start = 1'b1;  i_Stop = 1'b1;  i_Last_Idx = 3'd0;  i_Loop = 1'b0;
        @(posedge clk); #1;
        i_Start = 1'b0;  i_Stop = 1'b0;
        repeat (4) begin
            chk("startstop_busy", int'(o_Busy), 0);
            @(posedge clk); #1;
        end

        // Entry 1 rewritten after its prefetch: old on this pass, new on the next.
        wr(0, ent(1, 6, 2));
        wr(1, ent(2, 4, 2));
        t = cyc;  tp = t + 2;
        plan_cpi(tp, 0);  plan_cpi(tp, 1);  plan_cpi(tp, 0);
        do_start(1, 1'b1);
        wait_until(t + 5);
        wr(1, ent(6, 3, 3));
        cs = tp;
        plan_cpi(tp, 1);  plan_done(tp);
        wait_until(cs + 2);
        pulse_stop();
        wait_idle("prefetch");

        // Randomized tables and sequences.
        for (int it = 0; it < 10; it++) begin
            int last, k_tot, idx;
            bit loop;
            for (int a = 0; a < 8; a++) begin
                wr(a, ent(int'($urandom_range(0, 7)), int'($urandom_range(0, 12)),
                          int'($urandom_range(0, 4))));
            end
            last  = int'($urandom_range(0, 3));
            loop  = 1'($urandom_range(0, 1));
            k_tot = loop ? int'($urandom_range(1, 6)) : last + 1;
            t = cyc;  tp = t + 2;  idx = 0;  cs = tp;
            for (int k = 0; k < k_tot; k++) begin
                cs = tp;
                plan_cpi(tp, idx);
                idx = (idx == last) ? 0 : idx + 1;
            end
            plan_done(tp);
            do_start(last, loop);
            if (loop) begin
                s = int'($urandom_range(cs, tp - 2));
                wait_until(s);
                pulse_stop();
            end
            wait_idle("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hsc_cpi_sequencer.md
HSC_CPI_SEQUENCER -- requirements
Module: hsc_cpi_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 The block SHALL have no parameters; the dwell table depth is fixed at 8 entries.
REQ-003 The ports SHALL be, clock and reset first:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- i_Tbl_We  in  1  dwell-table write strobe
- i_Tbl_Addr  in  3  dwell-table write address
- i_Tbl_Wdata  in  35  {Waveform_Type[34:32], PRI_Width[31:16], CPI_Width[15:0]}
- i_Last_Idx  in  3  index of the last dwell entry used
- i_Loop  in  1  1 = restart at entry 0 after the last entry
- i_Start  in  1  start-sequence pulse
- i_Stop  in  1  stop request
- o_Busy  out  1  sequence running
- o_PRI_p  out  1  1-cycle pulse at each PRI start
- o_CPI_p  out  1  1-cycle pulse at each CPI start
- o_First_PRI  out  1  level, high for the whole first PRI of each CPI
- o_SRIO_Mem_Sel  out  1  ping-pong buffer select
- o_Waveform_Type  out  3  waveform of the current dwell
- o_PRI_Width  out  16  effective PRI width of the current dwell
- o_Dwell_Idx  out  3  current table index
- o_Done  out  1  1-cycle pulse at sequence end

Function
REQ-004 Table writes SHALL take effect on the clock edge where i_Tbl_We=1; they are accepted in any state.
REQ-005 Table contents SHALL NOT be cleared by reset.
REQ-006 The state machine SHALL have the states IDLE, LOAD, RUN and DONE.
REQ-007 In IDLE, i_Start=1 with i_Stop=0 SHALL latch i_Last_Idx and i_Loop, set the index to 0 and go to LOAD.
REQ-008 In IDLE, i_Start=1 with i_Stop=1 SHALL leave the block in IDLE.
REQ-009 i_Start SHALL be ignored in every state other than IDLE.
REQ-010 LOAD SHALL last 1 cycle, register entry[index] into the current-dwell registers, then go to RUN.
REQ-011 The first cycle of RUN SHALL assert o_PRI_p, o_CPI_p and o_First_PRI, so o_PRI_p appears 2 cycles after the i_Start edge.
REQ-012 Effective PRI width SHALL be max(PRI_Width, 2); effective CPI width SHALL be max(CPI_Width, 1).
REQ-013 The PRI counter SHALL count 0..PRI-1, and o_PRI_p SHALL be high when the counter is 0.
REQ-014 The PRI index SHALL count 0..CPI-1 and advance when the PRI counter wraps.
REQ-015 o_First_PRI SHALL be high exactly while the PRI index is 0.
REQ-016 The next entry (index+1, or 0 on wrap) SHALL be prefetched on the cycle o_CPI_p is high; later writes to that entry SHALL apply only to its next use.
REQ-017 At the last cycle of a CPI (PRI counter = PRI-1, PRI index = CPI-1), the block SHALL toggle o_SRIO_Mem_Sel and then act on the first matching case below.
REQ-018 Case 1, stop pending: go to DONE.
REQ-019 Case 2, index = latched last index and loop = 0: go to DONE.
REQ-020 Otherwise, the block SHALL move to the prefetched entry with no gap, so the next cycle carries o_PRI_p and o_CPI_p.
REQ-021 After the last entry with loop = 1, the index SHALL wrap to 0.
REQ-022 i_Stop while Busy SHALL set a sticky stop-pending flag; the current CPI always completes.
REQ-023 DONE SHALL last 1 cycle, assert o_Done, clear stop-pending, then go to IDLE.
REQ-024 o_Busy SHALL be high in LOAD and RUN.
REQ-025 o_Waveform_Type, o_PRI_Width and o_Dwell_Idx SHALL hold the last dwell's values in IDLE.
REQ-026 i_Last_Idx and i_Loop changes while Busy SHALL be ignored until the next start.
REQ-027 Counters SHALL be 16 bits unsigned with no overflow possible, since limits are compared before increment.

Reset
REQ-028 rst=1 SHALL force IDLE on the next edge, including mid-RUN, without producing o_Done.
REQ-029 Reset values SHALL be:
- all pulses 0
- o_Busy 0, o_First_PRI 0
- o_SRIO_Mem_Sel 0
- o_Waveform_Type 0, o_PRI_Width 0, o_Dwell_Idx 0
- counters 0, stop-pending 0

Verification
REQ-030 Single CPI: entry0={3,130,5}, Last_Idx=0, Loop=0, Start at cycle t -> o_PRI_p at t+2+130k for k=0..4, one o_CPI_p at t+2, o_First_PRI high cycles t+2..t+131, Mem_Sel 0->1 at t+652, o_Done at t+652.
REQ-031 Multi-dwell continuity: entries {0,10,2},{5,20,1}, Last_Idx=1 -> o_CPI_p at t+2 and t+22 (no gap), o_Waveform_Type 0 then 5, o_Done at t+42.
REQ-032 Width clamping: entry0 = {1,0,0} -> PRI period 2, one PRI per CPI, o_PRI_Width reads 2.
REQ-033 Loop and stop: Loop=1, Last_Idx=0, entry0={2,10,3}, i_Stop pulsed mid-second CPI -> second CPI finishes, Mem_Sel toggles twice, o_Done once, then IDLE.
REQ-034 Reset mid-RUN: rst at PRI index 2 -> next cycle all outputs at reset values, no o_Done, and a restart works normally.
REQ-035 Hazards:
- Start+Stop together in IDLE -> stays IDLE.
- Start while Busy -> ignored.
- Write to entry1 after the prefetch cycle -> old entry1 used this pass, new one on the next loop.
